// File: rtl/tt_um_addon_wide.sv
// Multi-byte add/subtract/accumulate unit with a byte-serial operand load and result readout.
// Operands and results are W = 8*NBYTES bits, transferred least-significant byte first.
module tt_um_addon_wide #(
  parameter int NBYTES = 2,
  parameter int SAT    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int W = 8 * NBYTES;
  localparam logic [1:0] LAST      = 2'(NBYTES - 1);
  localparam logic [1:0] FIRST_CNT = (NBYTES == 1) ? 2'd0 : 2'd1;

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ACC = 2'b10;
  localparam logic [1:0] M_CLR = 2'b11;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, OUT} state_t;

  state_t         state, state_n;
  logic [W-1:0]   a, b, r, acc;
  logic [1:0]     mode, cnt, rdptr;
  logic           carry, ovf;
  logic           busy, res_valid;

  logic           wr, rd;
  logic [1:0]     in_mode;
  logic [W-1:0]   op_x, op_y;
  logic [W:0]     sum_w, diff_w, raw_w;
  logic           ovf_w;
  logic           unused_uio;

  assign wr         = ena & uio_in[0];
  assign rd         = ena & uio_in[3];
  assign in_mode    = uio_in[2:1];
  assign unused_uio = ^uio_in[7:4];
  assign uio_oe     = 8'hF0;

  // ACC has no B operand, so it goes straight to CALC once A is complete.
  function automatic state_t after_a(input logic [1:0] m);
    return (m == M_ACC) ? CALC : LOAD_B;
  endfunction

  // Unsigned clamp: carry pins to all-ones, borrow pins to zero.
  function automatic logic [W-1:0] sat_result(input logic [W:0] raw, input logic [1:0] m);
    if (SAT != 0 && raw[W])
      return (m == M_SUB) ? {W{1'b0}} : {W{1'b1}};
    return raw[W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (wr && in_mode != M_CLR)
                 state_n = (NBYTES == 1) ? after_a(in_mode) : LOAD_A;
      LOAD_A:  if (wr && cnt == LAST) state_n = after_a(mode);
      LOAD_B:  if (wr && cnt == LAST) state_n = CALC;
      CALC:    state_n = OUT;
      OUT:     if (rd && rdptr == LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    res_valid = (state == OUT);
    uo_out    = 8'h00;
    if (res_valid)
      for (int i = 0; i < NBYTES; i++)
        if (rdptr == 2'(i)) uo_out = r[i*8 +: 8];
    uio_out = {ovf, carry, res_valid, busy, 4'b0000};
  end

  // Arithmetic stage: ADD/ACC share the adder, ACC adds A onto the accumulator.
  always_comb begin
    op_x   = (mode == M_ACC) ? acc : a;
    op_y   = (mode == M_ACC) ? a : b;
    sum_w  = {1'b0, op_x} + {1'b0, op_y};
    diff_w = {1'b0, a} - {1'b0, b};
    if (mode == M_SUB) begin
      raw_w = diff_w;
      ovf_w = (a[W-1] != b[W-1]) && (diff_w[W-1] != a[W-1]);
    end else begin
      raw_w = sum_w;
      ovf_w = (op_x[W-1] == op_y[W-1]) && (sum_w[W-1] != op_x[W-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a     <= '0;
      b     <= '0;
      r     <= '0;
      acc   <= '0;
      mode  <= '0;
      cnt   <= '0;
      rdptr <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (wr) begin
          if (in_mode == M_CLR) begin
            acc <= '0;
          end else begin
            mode     <= in_mode;
            a[7:0]   <= ui_in;
            cnt      <= FIRST_CNT;
          end
        end
        LOAD_A: if (wr) begin
          for (int i = 0; i < NBYTES; i++)
            if (cnt == 2'(i)) a[i*8 +: 8] <= ui_in;
          cnt <= (cnt == LAST) ? 2'd0 : cnt + 2'd1;
        end
        LOAD_B: if (wr) begin
          for (int i = 0; i < NBYTES; i++)
            if (cnt == 2'(i)) b[i*8 +: 8] <= ui_in;
          cnt <= (cnt == LAST) ? 2'd0 : cnt + 2'd1;
        end
        CALC: begin
          r     <= sat_result(raw_w, mode);
          carry <= raw_w[W];
          ovf   <= ovf_w;
          rdptr <= 2'd0;
          if (mode == M_ACC) acc <= sat_result(raw_w, mode);
        end
        OUT: if (rd && rdptr != LAST) rdptr <= rdptr + 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_um_addon_wide.sv
// Directed bench for tt_um_addon_wide: 2-byte wrap unit, 2-byte saturating unit and 1-byte unit.
module tb_tt_um_addon_wide;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena0, ena_s, ena1;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo0, uio0, oe0, uo_s, uio_s, oe_s, uo1, uio1, oe1;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  tt_um_addon_wide #(.NBYTES(2), .SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena0), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo0), .uio_out(uio0), .uio_oe(oe0));
  tt_um_addon_wide #(.NBYTES(2), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena_s), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_s), .uio_out(uio_s), .uio_oe(oe_s));
  tt_um_addon_wide #(.NBYTES(1), .SAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena1), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo1), .uio_out(uio1), .uio_oe(oe1));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_byte(input logic [1:0] m, input logic [7:0] d);
    @(negedge clk);
    ui_in  = d;
    uio_in = {5'b00000, m, 1'b1};
    @(posedge clk); #1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
  endtask

  task automatic rd_byte();
    @(negedge clk);
    uio_in = 8'h08;
    @(posedge clk); #1;
    uio_in = 8'h00;
  endtask

  // Later bytes carry mode 11 so a unit that resamples the mode goes wrong.
  task automatic op(input int nb, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < nb; i++) wr_byte((i == 0) ? m : 2'b11, a[i*8 +: 8]);
    if (m != 2'b10)
      for (int i = 0; i < nb; i++) wr_byte(2'b11, b[i*8 +: 8]);
  endtask

  task automatic read_res(input int nb, output logic [31:0] r0, output logic [31:0] rs,
                          output logic [31:0] r1);
    r0 = '0; rs = '0; r1 = '0;
    for (int i = 0; i < nb; i++) begin
      r0[i*8 +: 8] = uo0;
      rs[i*8 +: 8] = uo_s;
      r1[i*8 +: 8] = uo1;
      rd_byte();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena0 = 1'b0; ena_s = 1'b0; ena1 = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (uo0 !== 8'h00) begin errors++; $display("FAIL reset_uo got %h want 00", uo0); end
    checks++; if (uio0 !== 8'h00) begin errors++; $display("FAIL reset_uio got %h want 00", uio0); end
    checks++; if (oe0 !== 8'hF0) begin errors++; $display("FAIL reset_oe got %h want f0", oe0); end
    checks++; if (uio1 !== 8'h00) begin errors++; $display("FAIL reset_uio1 got %h want 00", uio1); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (oe0 !== 8'hF0) begin errors++; $display("FAIL run_oe got %h want f0", oe0); end
  endtask

  task automatic test_add_basic();
    logic [31:0] r0, rs, r1;
    ena0 = 1'b1;
    op(2, 2'b00, 32'h1234, 32'h0FCD);
    checks++; if (uio0 !== 8'h10) begin errors++; $display("FAIL add_calc_uio got %h want 10", uio0); end
    checks++; if (uo0 !== 8'h00) begin errors++; $display("FAIL add_calc_uo got %h want 00", uo0); end
    tick();
    checks++; if (uio0 !== 8'h30) begin errors++; $display("FAIL add_out_uio got %h want 30", uio0); end
    read_res(2, r0, rs, r1);
    checks++; if (r0[15:0] !== 16'h2201) begin errors++; $display("FAIL add_result got %h want 2201", r0[15:0]); end
    checks++; if (uio0 !== 8'h00) begin errors++; $display("FAIL add_idle_uio got %h want 00", uio0); end
  endtask

  task automatic test_carry_sat();
    logic [31:0] r0, rs, r1;
    ena0 = 1'b1; ena_s = 1'b1;
    op(2, 2'b00, 32'hFFFF, 32'h0001);
    tick();
    checks++; if (uio0 !== 8'h70) begin errors++; $display("FAIL carry_uio got %h want 70", uio0); end
    checks++; if (uio_s !== 8'h70) begin errors++; $display("FAIL sat_uio got %h want 70", uio_s); end
    read_res(2, r0, rs, r1);
    checks++; if (r0[15:0] !== 16'h0000) begin errors++; $display("FAIL carry_result got %h want 0000", r0[15:0]); end
    checks++; if (rs[15:0] !== 16'hFFFF) begin errors++; $display("FAIL sat_result got %h want ffff", rs[15:0]); end
    checks++; if (uio0 !== 8'h40) begin errors++; $display("FAIL carry_hold got %h want 40", uio0); end
    ena_s = 1'b0;
  endtask

  task automatic test_sub_ovf();
    logic [31:0] r0, rs, r1;
    op(2, 2'b01, 32'h0005, 32'h0007);
    tick();
    checks++; if (uio0 !== 8'h70) begin errors++; $display("FAIL sub_uio got %h want 70", uio0); end
    read_res(2, r0, rs, r1);
    checks++; if (r0[15:0] !== 16'hFFFE) begin errors++; $display("FAIL sub_result got %h want fffe", r0[15:0]); end
    op(2, 2'b00, 32'h7FFF, 32'h0001);
    tick();
    checks++; if (uio0 !== 8'hB0) begin errors++; $display("FAIL ovf_uio got %h want b0", uio0); end
    read_res(2, r0, rs, r1);
    checks++; if (r0[15:0] !== 16'h8000) begin errors++; $display("FAIL ovf_result got %h want 8000", r0[15:0]); end
  endtask

  task automatic test_acc();
    logic [31:0] r0, rs, r1;
    wr_byte(2'b11, 8'h55);
    checks++; if (uio0 !== 8'h80) begin errors++; $display("FAIL clr_uio got %h want 80", uio0); end
    for (int k = 1; k <= 3; k++) begin
      op(2, 2'b10, 32'h0100, 32'h0);
      tick();
      read_res(2, r0, rs, r1);
      checks++;
      if (r0[15:0] !== 16'(k * 256)) begin
        errors++; $display("FAIL acc_step%0d got %h want %h", k, r0[15:0], 16'(k * 256));
      end
    end
    op(2, 2'b00, 32'h0001, 32'h0001);
    tick();
    read_res(2, r0, rs, r1);
    checks++; if (r0[15:0] !== 16'h0002) begin errors++; $display("FAIL acc_add got %h want 0002", r0[15:0]); end
    op(2, 2'b10, 32'h0100, 32'h0);
    tick();
    read_res(2, r0, rs, r1);
    checks++; if (r0[15:0] !== 16'h0400) begin errors++; $display("FAIL acc_kept got %h want 0400", r0[15:0]); end
    wr_byte(2'b11, 8'h00);
    op(2, 2'b10, 32'h0001, 32'h0);
    tick();
    read_res(2, r0, rs, r1);
    checks++; if (r0[15:0] !== 16'h0001) begin errors++; $display("FAIL acc_clr got %h want 0001", r0[15:0]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r0, rs, r1;
    wr_byte(2'b00, 8'h01);
    wr_byte(2'b11, 8'h00);
    wr_byte(2'b11, 8'h05);
    checks++; if (uio0 !== 8'h10) begin errors++; $display("FAIL mid_busy got %h want 10", uio0); end
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (uio0 !== 8'h00) begin errors++; $display("FAIL mid_reset_uio got %h want 00", uio0); end
    checks++; if (uo0 !== 8'h00) begin errors++; $display("FAIL mid_reset_uo got %h want 00", uo0); end
    @(negedge clk); rst_n = 1'b1;
    op(2, 2'b00, 32'h0001, 32'h0001);
    tick();
    checks++; if (uio0 !== 8'h30) begin errors++; $display("FAIL fresh_uio got %h want 30", uio0); end
    read_res(2, r0, rs, r1);
    checks++; if (r0[15:0] !== 16'h0002) begin errors++; $display("FAIL fresh_result got %h want 0002", r0[15:0]); end
  endtask

  task automatic test_ena_gating();
    logic [31:0] r0, rs, r1;
    wr_byte(2'b00, 8'h78);
    wr_byte(2'b11, 8'h56);
    ena0 = 1'b0;
    wr_byte(2'b11, 8'hFF);
    wr_byte(2'b11, 8'hFF);
    checks++; if (uio0 !== 8'h10) begin errors++; $display("FAIL ena_hold got %h want 10", uio0); end
    ena0 = 1'b1;
    rd_byte();
    wr_byte(2'b11, 8'h11);
    wr_byte(2'b11, 8'h11);
    tick();
    checks++; if (uo0 !== 8'h89) begin errors++; $display("FAIL ena_lsb got %h want 89", uo0); end
    wr_byte(2'b00, 8'hAA);
    checks++; if (uio0 !== 8'h30) begin errors++; $display("FAIL out_wr_uio got %h want 30", uio0); end
    read_res(2, r0, rs, r1);
    checks++; if (r0[15:0] !== 16'h6789) begin errors++; $display("FAIL ena_result got %h want 6789", r0[15:0]); end
  endtask

  task automatic test_nbytes1();
    logic [31:0] r0, rs, r1;
    ena0 = 1'b0; ena1 = 1'b1;
    op(1, 2'b00, 32'hFF, 32'h01);
    checks++; if (uio1 !== 8'h10) begin errors++; $display("FAIL nb1_calc got %h want 10", uio1); end
    tick();
    checks++; if (uio1 !== 8'h70) begin errors++; $display("FAIL nb1_uio got %h want 70", uio1); end
    read_res(1, r0, rs, r1);
    checks++; if (r1[7:0] !== 8'h00) begin errors++; $display("FAIL nb1_result got %h want 00", r1[7:0]); end
    checks++; if (uio1 !== 8'h40) begin errors++; $display("FAIL nb1_idle got %h want 40", uio1); end
    ena1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry_sat();
    test_sub_ovf();
    test_acc();
    test_reset_mid();
    test_ena_gating();
    test_nbytes1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tt_um_addon_wide.md
TT_UM_ADDON_WIDE -- requirements
Module: tt_um_addon_wide

Interface
REQ-001 SHALL have parameter NBYTES, default 2, meaning operand/result width in bytes (legal 1..4, W = 8*NBYTES).
REQ-002 SHALL have parameter SAT, default 0, meaning unsigned saturation enable (0 = wrap, 1 = clamp).
REQ-003 clk  input  1  clock; single clock domain, all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 ena  input  1  design enable; strobes ignored while 0, state held.
REQ-006 ui_in  input  8  operand data byte.
REQ-007 uio_in  input  8  [0] wr strobe, [2:1] mode, [3] rd strobe, [7:4] unused.
REQ-008 uo_out  output  8  result byte at read pointer.
REQ-009 uio_out  output  8  [3:0]=0, [4] busy, [5] res_valid, [6] carry, [7] ovf.
REQ-010 uio_oe  output  8  constant 8'hF0.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, CALC, OUT; busy = (state != IDLE).
REQ-012 Each ena&wr cycle counts as one byte; no edge detection.
REQ-013 In IDLE, ena&wr SHALL latch mode=uio_in[2:1] and capture ui_in as A byte 0 (LS first).
REQ-014 Modes: 00 ADD, 01 SUB (A-B), 10 ACC (acc+A), 11 CLR.
REQ-015 CLR: acc <= 0, state stays IDLE, byte discarded, res_valid and flags unchanged.
REQ-016 LOAD_A captures A bytes 1..NBYTES-1; then ADD/SUB -> LOAD_B (NBYTES B bytes, LS first), ACC -> CALC; NBYTES=1 skips LOAD_A.
REQ-017 Mode SHALL be sampled only on the first byte; uio_in[2:1] ignored afterwards.
REQ-018 CALC lasts exactly one cycle, wr/rd ignored; result, carry, ovf registered at its end; res_valid=1 from the next cycle (state OUT).
REQ-019 ADD: {carry,R} = A+B (W+1 bits); ovf = signed overflow (A,B same sign, R differs).
REQ-020 SUB: R = A-B mod 2^W; carry = borrow (A<B unsigned); ovf = signed overflow (A,B differ in sign, R sign != A sign).
REQ-021 ACC: {carry,R} = acc+A; ovf signed as ADD; acc <= R (post-saturation).
REQ-022 SAT=1: carry on ADD/ACC clamps R to all-ones; borrow on SUB clamps R to 0; carry/ovf still report raw result.
REQ-023 uo_out = R byte[rdptr] when res_valid, else 8'h00; rdptr = 0 on entering OUT.
REQ-024 OUT: ena&rd advances rdptr; rd on byte NBYTES-1 -> IDLE, res_valid=0 next cycle; carry/ovf hold until next CALC.
REQ-025 wr ignored in OUT, CALC; rd ignored outside OUT; wr&rd together act per state, never both.
REQ-026 acc persists across ADD/SUB operations; only ACC, CLR and reset modify it.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, A, B, R, acc, rdptr, mode, carry, ovf = 0; res_valid=0, busy=0; uo_out=8'h00; uio_out=8'h00.
REQ-028 Reset mid-operation SHALL discard partial operands; after release, first wr starts a fresh operation.
REQ-029 uio_oe SHALL be 8'hF0 in and out of reset.

Verification (NBYTES=2 unless noted)
REQ-030 ADD bytes 34,12,CD,0F -> 1 CALC cycle, res_valid=1, uo_out 01 then (rd) 22, carry=0, ovf=0; then IDLE, busy=0.
REQ-031 ADD FFFF+0001 -> R=0000, carry=1 (SAT=0); SAT=1 -> R=FFFF, carry=1.
REQ-032 SUB 0005-0007 -> R=FFFE, carry=1, ovf=0; ADD 7FFF+0001 -> R=8000, ovf=1, carry=0.
REQ-033 CLR, then ACC 0100 three times -> results 0100, 0200, 0300; an interleaved ADD does not change acc; CLR then ACC 0001 -> 0001.
REQ-034 Reset asserted after 3 bytes of ADD -> all outputs 0, busy=0 immediately; new ADD 0001+0001 -> R=0002.
REQ-035 ena=0 during LOAD_B with wr pulses -> bytes ignored, state held; rd during LOAD ignored; wr during OUT ignored; NBYTES=1 ADD FF+01 -> R=00, carry=1.
